// File: rtl/idu_pkg.sv
// idu_pkg: shared definitions for the buffered decode queue.
//   - RV32I/RV64I major opcode constants and the ebreak encoding
//   - alu_op encoding (4 bits) and one-hot inst_type encoding (IRSBUJ)
//   - idu_bundle_t: decoded control/register bundle held in each FIFO entry
//   - alu_op_of(): maps funct3 plus the alternate bit (inst[30]) to an ALU op
// Optional build macro used by the decoder: IDU_RVE_EN (RV32E register range).
package idu_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   // One-hot instruction format, bit5 = I down to bit0 = J.
   localparam logic [5:0] TYPE_I = 6'b100000;
   localparam logic [5:0] TYPE_R = 6'b010000;
   localparam logic [5:0] TYPE_S = 6'b001000;
   localparam logic [5:0] TYPE_B = 6'b000100;
   localparam logic [5:0] TYPE_U = 6'b000010;
   localparam logic [5:0] TYPE_J = 6'b000001;

   typedef struct packed {
      logic [5:0] inst_type;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic [2:0] funct3;
      logic [3:0] alu_op;
      logic       alu_src;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       branch;
      logic       jump;
      logic       ebreak;
      logic       illegal;
   } idu_bundle_t;

   // alt selects SUB over ADD and SRA over SRL; it is ignored elsewhere.
   function automatic logic [3:0] alu_op_of(input logic [2:0] funct3, input logic alt);
      logic [3:0] op;
      case (funct3)
         3'd0:    op = alt ? ALU_SUB : ALU_ADD;
         3'd1:    op = ALU_SLL;
         3'd2:    op = ALU_SLT;
         3'd3:    op = ALU_SLTU;
         3'd4:    op = ALU_XOR;
         3'd5:    op = alt ? ALU_SRA : ALU_SRL;
         3'd6:    op = ALU_OR;
         3'd7:    op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/idu_dec_core.sv
// idu_dec_core: purely combinational RV32I/RV64I base-set decoder.
// Ports:
//   inst   [31:0]      raw instruction word
//   pc     [XLEN-1:0]  PC of inst (forwarded on pc_o so the entry travels as one unit)
//   bundle             decoded control/register bundle (idu_bundle_t)
//   imm    [XLEN-1:0]  sign-extended immediate for the decoded format
//   pc_o   [XLEN-1:0]  copy of pc
// Build macro: IDU_RVE_EN -- when defined, any used register index >= 16 is illegal.
module idu_dec_core import idu_pkg::*; #(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   input  logic [XLEN-1:0] pc,
   output idu_bundle_t     bundle,
   output logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] pc_o
);

   logic [6:0]      opcode_s;
   logic [2:0]      funct3_s;
   logic [6:0]      funct7_s;
   logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
   logic            shamt_ok_s;
   logic            ill_s;
   idu_bundle_t     dec_s;
   logic [XLEN-1:0] imm_raw_s;

   assign opcode_s = inst[6:0];
   assign funct3_s = inst[14:12];
   assign funct7_s = inst[31:25];

   assign imm_i_s = XLEN'($signed(inst[31:20]));
   assign imm_s_s = XLEN'($signed({inst[31:25], inst[11:7]}));
   assign imm_b_s = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
   assign imm_u_s = XLEN'($signed({inst[31:12], 12'h000}));
   assign imm_j_s = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

   // Shift-immediate upper field check; RV64 uses a 6-bit shamt so only inst[31:26] qualifies.
   always_comb begin
      if (XLEN == 64) begin
         shamt_ok_s = (inst[31:26] == 6'b000000) ||
                      ((inst[31:26] == 6'b010000) && (funct3_s == 3'd5));
      end else begin
         shamt_ok_s = (funct7_s == 7'h00) ||
                      ((funct7_s == 7'h20) && (funct3_s == 3'd5));
      end
   end

   // Main decode: format, register usage, ALU op, control flags and legality.
   always_comb begin
      dec_s        = '0;
      imm_raw_s    = '0;
      ill_s        = 1'b0;
      dec_s.funct3 = funct3_s;
      case (opcode_s)
         OPC_OP: begin
            dec_s.inst_type = TYPE_R;
            dec_s.rs1       = inst[19:15];
            dec_s.rs2       = inst[24:20];
            dec_s.rd        = inst[11:7];
            dec_s.alu_op    = alu_op_of(funct3_s, inst[30]);
            if ((funct7_s != 7'h00) && (funct7_s != 7'h20)) begin
               ill_s = 1'b1;
            end else if ((funct7_s == 7'h20) && (funct3_s != 3'd0) && (funct3_s != 3'd5)) begin
               ill_s = 1'b1;
            end else begin
               ill_s = 1'b0;
            end
         end
         OPC_OP_IMM: begin
            dec_s.inst_type = TYPE_I;
            dec_s.rs1       = inst[19:15];
            dec_s.rd        = inst[11:7];
            dec_s.alu_src   = 1'b1;
            dec_s.alu_op    = alu_op_of(funct3_s, (funct3_s == 3'd5) && inst[30]);
            imm_raw_s       = imm_i_s;
            ill_s           = ((funct3_s == 3'd1) || (funct3_s == 3'd5)) && !shamt_ok_s;
         end
         OPC_LOAD: begin
            dec_s.inst_type  = TYPE_I;
            dec_s.rs1        = inst[19:15];
            dec_s.rd         = inst[11:7];
            dec_s.alu_op     = ALU_ADD;
            dec_s.alu_src    = 1'b1;
            dec_s.mem_read   = 1'b1;
            dec_s.mem_to_reg = 1'b1;
            imm_raw_s        = imm_i_s;
            ill_s = (funct3_s == 3'd7) ||
                    ((XLEN == 32) && ((funct3_s == 3'd3) || (funct3_s == 3'd6)));
         end
         OPC_STORE: begin
            dec_s.inst_type = TYPE_S;
            dec_s.rs1       = inst[19:15];
            dec_s.rs2       = inst[24:20];
            dec_s.alu_op    = ALU_ADD;
            dec_s.alu_src   = 1'b1;
            dec_s.mem_write = 1'b1;
            imm_raw_s       = imm_s_s;
            ill_s = (XLEN == 32) ? (funct3_s > 3'd2) : (funct3_s > 3'd3);
         end
         OPC_BRANCH: begin
            dec_s.inst_type = TYPE_B;
            dec_s.rs1       = inst[19:15];
            dec_s.rs2       = inst[24:20];
            dec_s.alu_op    = ALU_SUB;
            dec_s.branch    = 1'b1;
            imm_raw_s       = imm_b_s;
            ill_s = (funct3_s == 3'd2) || (funct3_s == 3'd3);
         end
         OPC_JALR: begin
            dec_s.inst_type = TYPE_I;
            dec_s.rs1       = inst[19:15];
            dec_s.rd        = inst[11:7];
            dec_s.alu_op    = ALU_ADD;
            dec_s.alu_src   = 1'b1;
            dec_s.jump      = 1'b1;
            imm_raw_s       = imm_i_s;
            ill_s           = (funct3_s != 3'd0);
         end
         OPC_JAL: begin
            dec_s.inst_type = TYPE_J;
            dec_s.rd        = inst[11:7];
            dec_s.alu_op    = ALU_ADD;
            dec_s.alu_src   = 1'b1;
            dec_s.jump      = 1'b1;
            imm_raw_s       = imm_j_s;
         end
         OPC_LUI: begin
            dec_s.inst_type = TYPE_U;
            dec_s.rd        = inst[11:7];
            dec_s.alu_op    = ALU_PASSB;
            dec_s.alu_src   = 1'b1;
            imm_raw_s       = imm_u_s;
         end
         OPC_AUIPC: begin
            // EXU selects the PC as operand A for U-type with ADD.
            dec_s.inst_type = TYPE_U;
            dec_s.rd        = inst[11:7];
            dec_s.alu_op    = ALU_ADD;
            dec_s.alu_src   = 1'b1;
            imm_raw_s       = imm_u_s;
         end
         OPC_SYSTEM: begin
            if (inst == INST_EBREAK) begin
               dec_s.inst_type = TYPE_I;
               dec_s.ebreak    = 1'b1;
               imm_raw_s       = imm_i_s;
            end else begin
               ill_s = 1'b1;
            end
         end
         default: ill_s = 1'b1;
      endcase
`ifdef IDU_RVE_EN
      // Unused index fields are already zero, so only live registers are tested.
      ill_s = ill_s | dec_s.rs1[4] | dec_s.rs2[4] | dec_s.rd[4];
`endif
      // rd is only populated for R/I/U/J, so this also excludes S and B.
      dec_s.reg_write = (dec_s.rd != 5'd0);
      if (ill_s) begin
         dec_s         = '0;
         dec_s.funct3  = funct3_s;
         dec_s.illegal = 1'b1;
         imm_raw_s     = '0;
      end else begin
         dec_s.illegal = 1'b0;
      end
   end

   assign bundle = dec_s;
   assign imm    = imm_raw_s;
   assign pc_o   = pc;

endmodule

// File: rtl/idu_queue.sv
// idu_queue: buffered decode stage between IFU and EXU.
// Instructions accepted on the in_* valid/ready handshake are decoded by
// idu_dec_core and written into a DEPTH-entry FIFO; the head entry is shown on
// the out_* handshake (all payload zero while empty). flush empties the queue
// at the next edge and wins over push and pop.
// Ports: clk, rst (async, active high); in_valid/in_ready/in_inst/in_pc;
//   flush; out_valid/out_ready; decoded head fields out_pc .. out_illegal;
//   out_level (occupancy).
// Parameters: XLEN (32 or 64), DEPTH (power of two, >= 2).
// Build macro: IDU_RVE_EN (RV32E register range check inside the decoder).
module idu_queue import idu_pkg::*; #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_inst,
   input  logic [XLEN-1:0]            in_pc,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            out_pc,
   output logic [4:0]                 out_rs1,
   output logic [4:0]                 out_rs2,
   output logic [4:0]                 out_rd,
   output logic [2:0]                 out_funct3,
   output logic [XLEN-1:0]            out_imm,
   output logic [5:0]                 out_inst_type,
   output logic [3:0]                 out_alu_op,
   output logic                       out_alu_src,
   output logic                       out_mem_read,
   output logic                       out_mem_write,
   output logic                       out_mem_to_reg,
   output logic                       out_reg_write,
   output logic                       out_branch,
   output logic                       out_jump,
   output logic                       out_ebreak,
   output logic                       out_illegal,
   output logic [$clog2(DEPTH+1)-1:0] out_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   idu_bundle_t     dec_bundle_s;
   logic [XLEN-1:0] dec_imm_s, dec_pc_s;

   idu_bundle_t     bundle_q [DEPTH];
   idu_bundle_t     bundle_d [DEPTH];
   logic [XLEN-1:0] imm_q    [DEPTH];
   logic [XLEN-1:0] imm_d    [DEPTH];
   logic [XLEN-1:0] pc_q     [DEPTH];
   logic [XLEN-1:0] pc_d     [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic            full_s, empty_s, push_s, pop_s;
   idu_bundle_t     head_s;
   logic [XLEN-1:0] head_imm_s, head_pc_s;

   idu_dec_core #(.XLEN(XLEN)) u_dec (
      .inst   (in_inst),
      .pc     (in_pc),
      .bundle (dec_bundle_s),
      .imm    (dec_imm_s),
      .pc_o   (dec_pc_s)
   );

   // Full blocks a push even when a pop happens in the same cycle.
   assign full_s    = (level_q == LW'(DEPTH));
   assign empty_s   = (level_q == '0);
   assign in_ready  = !full_s;
   assign out_valid = !empty_s;
   assign push_s    = in_valid && !full_s && !flush;
   assign pop_s     = out_ready && !empty_s && !flush;

   // Next-state pointers and occupancy; flush clears everything.
   always_comb begin
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
         rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
         case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // Write the decoded bundle into the slot at the write pointer.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         if (push_s && (wr_ptr_q == AW'(i))) begin
            bundle_d[i] = dec_bundle_s;
            imm_d[i]    = dec_imm_s;
            pc_d[i]     = dec_pc_s;
         end else begin
            bundle_d[i] = bundle_q[i];
            imm_d[i]    = imm_q[i];
            pc_d[i]     = pc_q[i];
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            bundle_q[i] <= '0;
            imm_q[i]    <= '0;
            pc_q[i]     <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         for (int i = 0; i < DEPTH; i++) begin
            bundle_q[i] <= bundle_d[i];
            imm_q[i]    <= imm_d[i];
            pc_q[i]     <= pc_d[i];
         end
      end
   end

   // Head entry, forced to zero while the queue is empty.
   always_comb begin
      if (empty_s) begin
         head_s     = '0;
         head_imm_s = '0;
         head_pc_s  = '0;
      end else begin
         head_s     = bundle_q[rd_ptr_q];
         head_imm_s = imm_q[rd_ptr_q];
         head_pc_s  = pc_q[rd_ptr_q];
      end
   end

   assign out_pc         = head_pc_s;
   assign out_imm        = head_imm_s;
   assign out_rs1        = head_s.rs1;
   assign out_rs2        = head_s.rs2;
   assign out_rd         = head_s.rd;
   assign out_funct3     = head_s.funct3;
   assign out_inst_type  = head_s.inst_type;
   assign out_alu_op     = head_s.alu_op;
   assign out_alu_src    = head_s.alu_src;
   assign out_mem_read   = head_s.mem_read;
   assign out_mem_write  = head_s.mem_write;
   assign out_mem_to_reg = head_s.mem_to_reg;
   assign out_reg_write  = head_s.reg_write;
   assign out_branch     = head_s.branch;
   assign out_jump       = head_s.jump;
   assign out_ebreak     = head_s.ebreak;
   assign out_illegal    = head_s.illegal;
   assign out_level      = level_q;

endmodule

// File: tb/tb_idu_queue.sv
// tb_idu_queue: scoreboard bench for idu_queue (XLEN=32, DEPTH=4).
// Expected decode results come from a hand-written table; an entry is queued
// when the bench model sees a push and compared when the model sees a pop.
module tb_idu_queue;
   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
   localparam int NTAB  = 16;

   localparam logic [5:0] T_I = 6'b100000;
   localparam logic [5:0] T_R = 6'b010000;
   localparam logic [5:0] T_S = 6'b001000;
   localparam logic [5:0] T_B = 6'b000100;
   localparam logic [5:0] T_U = 6'b000010;
   localparam logic [5:0] T_J = 6'b000001;
   // flag order: alu_src mem_read mem_write mem_to_reg reg_write branch jump ebreak illegal
   localparam logic [8:0] F_ILL = 9'b0_0000_0001;

   logic clk = 1'b0;
   logic rst, in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] in_inst;
   logic [XLEN-1:0] in_pc, out_pc, out_imm;
   logic [4:0] out_rs1, out_rs2, out_rd;
   logic [2:0] out_funct3;
   logic [5:0] out_inst_type;
   logic [3:0] out_alu_op;
   logic out_alu_src, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write;
   logic out_branch, out_jump, out_ebreak, out_illegal;
   logic [$clog2(DEPTH+1)-1:0] out_level;

   typedef struct {
      logic [100:0] v;
      logic [100:0] m;
   } sb_t;

   sb_t         sb_q[$];
   sb_t         cur;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] pc_cnt;
   logic [31:0] t_inst [NTAB];
   logic [68:0] t_exp  [NTAB];
   logic [68:0] t_msk  [NTAB];

   always #5 clk = ~clk;

   idu_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_funct3(out_funct3), .out_imm(out_imm), .out_inst_type(out_inst_type),
      .out_alu_op(out_alu_op), .out_alu_src(out_alu_src),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
      .out_branch(out_branch), .out_jump(out_jump), .out_ebreak(out_ebreak),
      .out_illegal(out_illegal), .out_level(out_level)
   );

   task automatic chk_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [68:0] mk(input logic [5:0] t, input logic [4:0] r1, input logic [4:0] r2,
                                      input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] imm,
                                      input logic [3:0] alu, input logic [8:0] fl);
      return {t, r1, r2, rd, f3, imm, alu, fl};
   endfunction

   function automatic logic [100:0] dut_pack();
      return {out_pc, out_inst_type, out_rs1, out_rs2, out_rd, out_funct3, out_imm, out_alu_op,
              out_alu_src, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write,
              out_branch, out_jump, out_ebreak, out_illegal};
   endfunction

   task automatic set_row(input int i, input logic [31:0] inst, input logic [68:0] e, input logic [68:0] m);
      t_inst[i] = inst;
      t_exp[i]  = e;
      t_msk[i]  = m;
   endtask

   task automatic init_tables();
      logic [68:0] all_m;
      all_m = '1;
      set_row(0,  32'hFFF10093, mk(T_I, 5'd2, 5'd0, 5'd1, 3'd0, 32'hFFFFFFFF, 4'd0, 9'b1_0001_0000), all_m);
      set_row(1,  32'hFFDFF06F, mk(T_J, 5'd0, 5'd0, 5'd0, 3'd7, 32'hFFFFFFFC, 4'd0, 9'b1_0000_0100), all_m);
      set_row(2,  32'h002081B3, mk(T_R, 5'd1, 5'd2, 5'd3, 3'd0, 32'h0, 4'd0, 9'b0_0001_0000), all_m);
      set_row(3,  32'h407302B3, mk(T_R, 5'd6, 5'd7, 5'd5, 3'd0, 32'h0, 4'd1, 9'b0_0001_0000), all_m);
      set_row(4,  32'h0020A423, mk(T_S, 5'd1, 5'd2, 5'd0, 3'd2, 32'h8, 4'd0, 9'b1_0100_0000), all_m);
      set_row(5,  32'h00209863, mk(T_B, 5'd1, 5'd2, 5'd0, 3'd1, 32'h10, 4'd1, 9'b0_0000_1000), all_m);
      set_row(6,  32'h12345537, mk(T_U, 5'd0, 5'd0, 5'd10, 3'd5, 32'h12345000, 4'd10, 9'b1_0001_0000), all_m);
      set_row(7,  32'hFFC1A203, mk(T_I, 5'd3, 5'd0, 5'd4, 3'd2, 32'hFFFFFFFC, 4'd0, 9'b1_1011_0000), all_m);
      set_row(8,  32'h4033D313, mk(T_I, 5'd7, 5'd0, 5'd6, 3'd5, 32'h403, 4'd7, 9'b1_0001_0000), all_m);
      set_row(9,  32'h00007003, mk(6'd0, 5'd0, 5'd0, 5'd0, 3'd7, 32'h0, 4'd0, F_ILL), all_m);
      set_row(10, 32'h00100073, mk(6'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0, 4'd0, 9'b0_0000_0010), 69'h3);
      set_row(11, 32'h00001067, mk(6'd0, 5'd0, 5'd0, 5'd0, 3'd1, 32'h0, 4'd0, F_ILL), all_m);
      set_row(12, 32'h02000033, mk(6'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0, 4'd0, F_ILL), all_m);
      set_row(13, 32'h40001013, mk(6'd0, 5'd0, 5'd0, 5'd0, 3'd1, 32'h0, 4'd0, F_ILL), all_m);
      set_row(14, 32'h00002063, mk(6'd0, 5'd0, 5'd0, 5'd0, 3'd2, 32'h0, 4'd0, F_ILL), all_m);
`ifdef IDU_RVE_EN
      set_row(15, 32'h00000833, mk(6'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0, 4'd0, F_ILL), all_m);
`else
      set_row(15, 32'h00000833, mk(T_R, 5'd0, 5'd0, 5'd16, 3'd0, 32'h0, 4'd0, 9'b0_0001_0000), all_m);
`endif
   endtask

   task automatic drive(input int idx, input logic v);
      in_valid = v;
      in_inst  = t_inst[idx];
      in_pc    = pc_cnt;
      cur.v    = {pc_cnt, t_exp[idx]};
      cur.m    = {32'hFFFFFFFF, t_msk[idx]};
      pc_cnt   = pc_cnt + 32'd4;
   endtask

   // One clock: check handshake state against the model, compare a popped
   // head with the scoreboard, then advance the model past the edge.
   task automatic tick();
      bit pu, po;
      pu = in_valid && (sb_q.size() < DEPTH) && !flush;
      po = out_ready && (sb_q.size() != 0) && !flush;
      chk_val("in_ready", in_ready, sb_q.size() < DEPTH);
      chk_val("out_valid", out_valid, sb_q.size() != 0);
      if (sb_q.size() == 0) begin
         chk_val("empty_payload", dut_pack(), '0);
      end else if (po) begin
         chk_val("head", dut_pack() & sb_q[0].m, sb_q[0].v & sb_q[0].m);
      end
      @(posedge clk);
      #1;
      if (flush) begin
         sb_q.delete();
      end else begin
         if (po) void'(sb_q.pop_front());
         if (pu) sb_q.push_back(cur);
      end
      chk_val("level", out_level, sb_q.size());
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0;
      flush = 1'b0; out_ready = 1'b0; pc_cnt = 32'h0000_1000;
      init_tables();
      #1;
      chk_val("rst_out_valid", out_valid, 1'b0);
      chk_val("rst_level", out_level, 0);
      chk_val("rst_payload", dut_pack(), '0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      tick();

      // Streaming decode of every table row with EXU always ready.
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         drive(i, 1'b1);
         tick();
      end
      in_valid = 1'b0;
      tick();
      tick();

      // Fill to full, attempt a push while full, pop with push blocked, wrap.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(i + 2, 1'b1);
         tick();
      end
      drive(6, 1'b1);
      tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
      out_ready = 1'b1;
      for (int i = 7; i < 10; i++) begin
         drive(i, 1'b1);
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();

      // Flush with a simultaneous push at level 3.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(i, 1'b1);
         tick();
      end
      flush = 1'b1;
      drive(3, 1'b1);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      tick();

      // Asynchronous reset mid-stream at level 2.
      for (int i = 0; i < 2; i++) begin
         drive(i + 4, 1'b1);
         tick();
      end
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk_val("async_rst_out_valid", out_valid, 1'b0);
      chk_val("async_rst_level", out_level, 0);
      chk_val("async_rst_payload", dut_pack(), '0);
      sb_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      tick();

      // add x16,x0,x0: legal on RV32I, illegal with the RV32E range check.
      out_ready = 1'b1;
      drive(15, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
